// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the DMEM burst controller: op codes, FSM states and
// memory geometry.
package dmem_ctrl_pkg;

  localparam int DMEM_AW    = 5;
  localparam int DMEM_DW    = 16;
  localparam int DMEM_DEPTH = 32;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_CP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_FILL,
    ST_CP_RD,
    ST_CP_WR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/dmem_burst_cnt.sv
// Burst offset counter: holds k, flags the last word of an N-word burst and
// produces the wrapped source/destination addresses base+k.
module dmem_burst_cnt #(
  parameter int AW = 5,
  parameter int LW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [LW-1:0] len_i,
  input  logic [AW-1:0] src_base_i,
  input  logic [AW-1:0] dst_base_i,
  output logic          last_o,
  output logic [AW-1:0] src_addr_o,
  output logic [AW-1:0] dst_addr_o
);

  logic [LW-1:0] k_q, k_d;

  always_comb begin
    k_d = k_q;
    if (clr_i) begin
      k_d = '0;
    end else if (inc_i) begin
      k_d = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  // Truncating to AW bits gives the modulo-depth wrap for free.
  assign last_o     = (k_q == (len_i - 1'b1));
  assign src_addr_o = src_base_i + k_q[AW-1:0];
  assign dst_addr_o = dst_base_i + k_q[AW-1:0];

endmodule

// File: rtl/dmem_burst_ctrl.sv
// Burst sequencer driving the 32x16 DMEM: read, streamed write, fill and copy
// requests are turned into per-cycle address / write-enable / write-data.
module dmem_burst_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW,
  parameter int LW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [AW-1:0] req_dst_i,
  input  logic [LW-1:0] req_len_i,
  input  logic [DW-1:0] req_data_i,
  input  logic          wdata_valid_i,
  output logic          wdata_ready_o,
  input  logic [DW-1:0] wdata_i,
  output logic          rdata_valid_o,
  output logic [DW-1:0] rdata_o,
  output logic          done_o,
  output logic          busy_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_wen_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam logic [LW-1:0] MAX_LEN = LW'(2 ** AW);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [LW-1:0] len_q, len_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;

  logic          cnt_clr, cnt_inc, cnt_last;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] len_eff;

  assign len_eff = (req_len_i > MAX_LEN) ? MAX_LEN : req_len_i;

  dmem_burst_cnt #(
    .AW (AW),
    .LW (LW)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .len_i      (len_q),
    .src_base_i (addr_q),
    .dst_base_i (dst_q),
    .last_o     (cnt_last),
    .src_addr_o (src_addr),
    .dst_addr_o (dst_addr)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    dst_d         = dst_q;
    fill_d        = fill_q;
    len_d         = len_q;
    hold_d        = hold_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    req_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    done_o        = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_wen_o     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          dst_d   = req_dst_i;
          fill_d  = req_data_i;
          len_d   = len_eff;
          cnt_clr = 1'b1;
          if (len_eff == '0) begin
            state_d = ST_DONE;
          end else begin
            unique case (req_op_i)
              OP_RD:   state_d = ST_RD;
              OP_WR:   state_d = ST_WR;
              OP_FILL: state_d = ST_FILL;
              default: state_d = ST_CP_RD;
            endcase
          end
        end
      end
      ST_RD: begin
        mem_addr_o    = src_addr;
        rdata_d       = mem_rdata_i;
        rdata_valid_d = 1'b1;
        cnt_inc       = 1'b1;
        if (cnt_last) state_d = ST_DONE;
      end
      ST_WR: begin
        wdata_ready_o = 1'b1;
        mem_addr_o    = src_addr;
        mem_wdata_o   = wdata_i;
        mem_wen_o     = wdata_valid_i;
        if (wdata_valid_i) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_d = ST_DONE;
        end
      end
      ST_FILL: begin
        mem_addr_o  = src_addr;
        mem_wdata_o = fill_q;
        mem_wen_o   = 1'b1;
        cnt_inc     = 1'b1;
        if (cnt_last) state_d = ST_DONE;
      end
      ST_CP_RD: begin
        mem_addr_o = src_addr;
        hold_d     = mem_rdata_i;
        state_d    = ST_CP_WR;
      end
      ST_CP_WR: begin
        mem_addr_o  = dst_addr;
        mem_wdata_o = hold_q;
        mem_wen_o   = 1'b1;
        cnt_inc     = 1'b1;
        state_d     = cnt_last ? ST_DONE : ST_CP_RD;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      dst_q         <= '0;
      fill_q        <= '0;
      len_q         <= '0;
      hold_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      dst_q         <= dst_d;
      fill_q        <= fill_d;
      len_q         <= len_d;
      hold_q        <= hold_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign rdata_valid_o = rdata_valid_q;
  assign rdata_o       = rdata_q;

endmodule

// File: tb/tb_dmem_burst_ctrl.sv
// Self-checking bench for dmem_burst_ctrl: a transaction-level model expands each
// request into an expected per-cycle trace and a reference memory image.
module tb_dmem_burst_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [4:0]  req_addr_i;
  logic [4:0]  req_dst_i;
  logic [5:0]  req_len_i;
  logic [15:0] req_data_i;
  logic        wdata_valid_i;
  logic        wdata_ready_o;
  logic [15:0] wdata_i;
  logic        rdata_valid_o;
  logic [15:0] rdata_o;
  logic        done_o;
  logic        busy_o;
  logic [4:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_wen_o;
  logic [15:0] mem_rdata_i;

  dmem_burst_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_addr_i    (req_addr_i),
    .req_dst_i     (req_dst_i),
    .req_len_i     (req_len_i),
    .req_data_i    (req_data_i),
    .wdata_valid_i (wdata_valid_i),
    .wdata_ready_o (wdata_ready_o),
    .wdata_i       (wdata_i),
    .rdata_valid_o (rdata_valid_o),
    .rdata_o       (rdata_o),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_wen_o     (mem_wen_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DMEM: falling-edge write, combinational read; preload happens during reset.
  logic [15:0] dmem [32];
  logic        preload;
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) dmem[i] <= 16'h0100 + 16'(i);
    end else if (mem_wen_o) begin
      dmem[mem_addr_o] <= mem_wdata_o;
    end
  end
  assign mem_rdata_i = dmem[mem_addr_o];

  typedef struct {
    bit          wen;
    bit          chk_addr;
    logic [4:0]  addr;
    logic [15:0] wdata;
    bit          rdv;
    logic [15:0] rdata;
    bit          done;
    bit          wrdy;
    bit          wvalid;
    logic [15:0] wdin;
  } cyc_t;

  cyc_t        trace[$];
  logic [15:0] ref_mem [32];
  bit          dir_v[$];
  logic [15:0] dir_d[$];
  logic [15:0] rd_seen[$];
  int          wen_seen;
  int          errors;
  int          checks;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t blank_cycle();
    cyc_t c;
    c.wen = 0; c.chk_addr = 0; c.addr = '0; c.wdata = '0; c.rdv = 0; c.rdata = '0;
    c.done = 0; c.wrdy = 0; c.wvalid = bit'($urandom_range(0, 1)); c.wdin = 16'($urandom);
    return c;
  endfunction

  function automatic logic [4:0] wrap(input logic [4:0] base, input int off);
    return 5'((int'(base) + off) % 32);
  endfunction

  // Model: expand one request into the cycles that follow acceptance.
  task automatic buildTrace(input logic [1:0] op, input logic [4:0] a, input logic [4:0] d,
                            input logic [5:0] len, input logic [15:0] fv);
    int   n;
    int   k;
    cyc_t c;
    trace.delete();
    n = (int'(len) > 32) ? 32 : int'(len);
    if (n > 0) begin
      case (op)
        2'b00: for (int i = 0; i < n; i++) begin
          c = blank_cycle();
          c.chk_addr = 1; c.addr = wrap(a, i);
          c.rdv = (i > 0);
          if (i > 0) c.rdata = ref_mem[wrap(a, i - 1)];
          trace.push_back(c);
        end
        2'b01: begin
          k = 0;
          while (k < n) begin
            c = blank_cycle();
            if (dir_v.size() > 0) begin
              c.wvalid = dir_v.pop_front();
              c.wdin = dir_d.pop_front();
            end else begin
              c.wvalid = ($urandom_range(0, 2) != 0);
            end
            c.wrdy = 1; c.chk_addr = 1; c.addr = wrap(a, k);
            c.wen = c.wvalid; c.wdata = c.wdin;
            if (c.wvalid) begin
              ref_mem[wrap(a, k)] = c.wdin;
              k++;
            end
            trace.push_back(c);
          end
        end
        2'b10: for (int i = 0; i < n; i++) begin
          c = blank_cycle();
          c.chk_addr = 1; c.addr = wrap(a, i); c.wen = 1; c.wdata = fv;
          ref_mem[wrap(a, i)] = fv;
          trace.push_back(c);
        end
        default: for (int i = 0; i < n; i++) begin
          c = blank_cycle();
          c.chk_addr = 1; c.addr = wrap(a, i);
          trace.push_back(c);
          c = blank_cycle();
          c.chk_addr = 1; c.addr = wrap(d, i); c.wen = 1;
          c.wdata = ref_mem[wrap(a, i)];
          ref_mem[wrap(d, i)] = c.wdata;
          trace.push_back(c);
        end
      endcase
    end
    c = blank_cycle();
    c.done = 1;
    if (op == 2'b00 && n > 0) begin
      c.rdv = 1;
      c.rdata = ref_mem[wrap(a, n - 1)];
    end
    trace.push_back(c);
  endtask

  task automatic checkOutput(input cyc_t c);
    chk("busy", busy_o, 1'b1);
    chk("req_ready", req_ready_o, 1'b0);
    chk("wdata_ready", wdata_ready_o, c.wrdy);
    chk("mem_wen", mem_wen_o, c.wen);
    if (c.chk_addr) chk("mem_addr", mem_addr_o, c.addr);
    if (c.wen) chk("mem_wdata", mem_wdata_o, c.wdata);
    chk("rdata_valid", rdata_valid_o, c.rdv);
    if (c.rdv) chk("rdata", rdata_o, c.rdata);
    chk("done", done_o, c.done);
    if (rdata_valid_o) rd_seen.push_back(rdata_o);
    if (mem_wen_o) wen_seen++;
  endtask

  task automatic checkIdle();
    chk("idle_ready", req_ready_o, 1'b1);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_done", done_o, 1'b0);
    chk("idle_wen", mem_wen_o, 1'b0);
    chk("idle_rdv", rdata_valid_o, 1'b0);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] a, input logic [4:0] d,
                               input logic [5:0] len, input logic [15:0] fv);
    buildTrace(op, a, d, len, fv);
    rd_seen.delete();
    wen_seen = 0;
    @(posedge clk); #1;
    req_valid_i = 1; req_op_i = op; req_addr_i = a; req_dst_i = d;
    req_len_i = len; req_data_i = fv;
    wdata_valid_i = 0;
    #2 checkIdle();
    foreach (trace[i]) begin
      @(posedge clk); #1;
      // Garbage requests while busy must be ignored.
      req_valid_i = bit'($urandom_range(0, 1));
      req_op_i = 2'($urandom); req_addr_i = 5'($urandom); req_dst_i = 5'($urandom);
      req_len_i = 6'($urandom); req_data_i = 16'($urandom);
      wdata_valid_i = trace[i].wvalid;
      wdata_i = trace[i].wdin;
      #2 checkOutput(trace[i]);
    end
    @(posedge clk); #1;
    req_valid_i = 0; wdata_valid_i = 0;
    #2 checkIdle();
  endtask

  task automatic compareMem(input string tag);
    for (int i = 0; i < 32; i++) chk(tag, dmem[i], ref_mem[i]);
  endtask

  initial begin
    errors = 0; checks = 0; wen_seen = 0;
    rst_n = 0; preload = 1;
    req_valid_i = 0; req_op_i = 0; req_addr_i = 0; req_dst_i = 0; req_len_i = 0;
    req_data_i = 0; wdata_valid_i = 0; wdata_i = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'h0100 + 16'(i);
    repeat (2) @(posedge clk);
    #1 preload = 0;
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wen", mem_wen_o, 1'b0);
    chk("rst_addr", mem_addr_o, 5'd0);
    chk("rst_wdata", mem_wdata_o, 16'h0);
    chk("rst_rdata", rdata_o, 16'h0);
    chk("rst_rdv", rdata_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_wrdy", wdata_ready_o, 1'b0);
    @(posedge clk); #1 rst_n = 1;

    // Read wrapping past address 31.
    applyStimulus(2'b00, 5'd30, 5'd0, 6'd4, 16'h0);
    chk("rd_count", 16'(rd_seen.size()), 16'd4);
    if (rd_seen.size() == 4) begin
      chk("rd_w0", rd_seen[0], 16'h011E);
      chk("rd_w1", rd_seen[1], 16'h011F);
      chk("rd_w2", rd_seen[2], 16'h0100);
      chk("rd_w3", rd_seen[3], 16'h0101);
    end

    // Copy 2..5 -> 10..13.
    applyStimulus(2'b11, 5'd2, 5'd10, 6'd4, 16'h0);
    chk("cp_trace_len", 16'(trace.size()), 16'd9);
    chk("cp_w10", dmem[10], 16'h0102);
    chk("cp_w13", dmem[13], 16'h0105);

    // Streamed write with gaps.
    dir_v = '{1, 0, 1, 0, 1};
    dir_d = '{16'hAAAA, 16'h1234, 16'hBBBB, 16'h5678, 16'hCCCC};
    applyStimulus(2'b01, 5'd5, 5'd0, 6'd3, 16'h0);
    chk("wr_wen_count", 16'(wen_seen), 16'd3);
    chk("wr_w5", dmem[5], 16'hAAAA);
    chk("wr_w6", dmem[6], 16'hBBBB);
    chk("wr_w7", dmem[7], 16'hCCCC);
    chk("wr_w8", dmem[8], 16'h0108);
    compareMem("mem_directed");

    // Zero-length requests of every op.
    for (int op = 0; op < 4; op++) applyStimulus(2'(op), 5'd7, 5'd9, 6'd0, 16'hDEAD);

    // Reset in the middle of a write burst after two words.
    @(posedge clk); #1;
    req_valid_i = 1; req_op_i = 2'b01; req_addr_i = 5'd20; req_len_i = 6'd5;
    @(posedge clk); #1;
    req_valid_i = 0; wdata_valid_i = 1; wdata_i = 16'h1111;
    #2 chk("rw_wen0", mem_wen_o, 1'b1);
    @(posedge clk); #1 wdata_i = 16'h2222;
    #2 chk("rw_wen1", mem_wen_o, 1'b1);
    @(posedge clk); #1 wdata_i = 16'h3333;
    #1 rst_n = 0;
    #1;
    chk("rw_rst_wen", mem_wen_o, 1'b0);
    chk("rw_rst_busy", busy_o, 1'b0);
    chk("rw_rst_done", done_o, 1'b0);
    @(posedge clk); #1 wdata_valid_i = 0; rst_n = 1;
    #2 chk("rw_ready", req_ready_o, 1'b1);
    ref_mem[20] = 16'h1111;
    ref_mem[21] = 16'h2222;
    chk("rw_w20", dmem[20], 16'h1111);
    chk("rw_w21", dmem[21], 16'h2222);
    chk("rw_w22", dmem[22], 16'h0116);
    applyStimulus(2'b00, 5'd19, 5'd0, 6'd4, 16'h0);

    // Fill with over-long length clamps to the full memory.
    applyStimulus(2'b10, 5'd0, 5'd0, 6'd40, 16'hBEEF);
    chk("fill_wen_count", 16'(wen_seen), 16'd32);
    chk("fill_w0", dmem[0], 16'hBEEF);
    chk("fill_w31", dmem[31], 16'hBEEF);
    compareMem("mem_fill");

    // Randomized mix of all ops, lengths and (possibly overlapping) regions.
    for (int t = 0; t < 40; t++) begin
      applyStimulus(2'($urandom), 5'($urandom), 5'($urandom),
                    6'($urandom_range(0, 40)), 16'($urandom));
    end
    compareMem("mem_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
